qam_symbol_source: RTL and testbench

Parametrised M-QAM baseband symbol source. A PRBS generator, Gray-coded symbol mapper and upsampler are merged into one pipelined block. It emits signed I/Q level samples at UPSAMPLE samples per symbol over a valid/ready stream. The block sits at the head of the QAM transmit chain and feeds the I and Q pulse-shaping FIR pair. It generalises the fixed 16-QAM chain to 4/16/64-QAM, a configurable PRBS length, zero-stuff or hold upsampling, seed loading and backpressure.

---
 rtl/qam_src_pkg.sv | 32 +++
 rtl/prbs_lfsr.sv | 43 ++++
 rtl/qam_symbol_source.sv | 129 ++++++++++++
 tb/tb_qam_symbol_source.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_src_pkg.sv
// Shared types and helpers for the QAM symbol source: FSM state, PRBS tap lookup,
// and the per-axis Gray-to-level mapping.
package qam_src_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int lfsr_tap(input int w);
    case (w)
      7:       return 6;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return w - 1;
    endcase
  endfunction

  // Gray-decode k bits (MSB first) to n, then centre: 2n - (2^k - 1)
  function automatic int gray_to_level(input logic [2:0] g, input int k);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (i < k) begin
        acc = acc ^ g[i];
        n   = n * 2 + int'(acc);
      end
    end
    return 2 * n - ((1 << k) - 1);
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS register that advances STEP bits per cycle; bits_out[STEP-1] is
// the first bit generated from the current state.
module prbs_lfsr import qam_src_pkg::*; #(
  parameter int WIDTH = 15,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step_en,
  output logic [STEP-1:0]  bits_out
);

  localparam int TAP = lfsr_tap(WIDTH);

  logic [WIDTH-1:0] lfsr_q, lfsr_d, adv;
  logic             nb;

  always_comb begin
    adv      = lfsr_q;
    bits_out = '0;
    nb       = 1'b0;
    for (int k = STEP - 1; k >= 0; k--) begin
      nb          = adv[WIDTH-1] ^ adv[TAP-1];
      bits_out[k] = nb;
      adv         = {adv[WIDTH-2:0], nb};
    end
  end

  // All-zero seed would lock the register, so it is replaced by all ones
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = (seed == '0) ? '1 : seed;
    else if (step_en) lfsr_d = adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= '1;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/qam_symbol_source.sv
// M-QAM symbol source: PRBS -> Gray mapper -> zero-stuff/hold upsampler on a
// valid/ready stream. Define QAM_SRC_SYM_COUNT_EN to build the emitted-symbol counter.
module qam_symbol_source import qam_src_pkg::*; #(
  parameter  int BITS_PER_SYM = 4,
  parameter  int UPSAMPLE     = 4,
  parameter  int LFSR_WIDTH   = 15,
  localparam int K            = BITS_PER_SYM / 2,
  localparam int LEVEL_W      = K + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      hold_mode,
  input  logic                      seed_load,
  input  logic [LFSR_WIDTH-1:0]     seed,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic signed [LEVEL_W-1:0] i_out,
  output logic signed [LEVEL_W-1:0] q_out,
  output logic                      sym_strobe,
  output logic [31:0]               sym_count
);

  localparam int              PH_W    = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);

  state_t                    state_q, state_d;
  logic [PH_W-1:0]           ph_q, ph_d;
  logic signed [LEVEL_W-1:0] i_q, i_d, q_q, q_d, lvl_i, lvl_q;
  logic                      hold_q, hold_d, strobe_q, strobe_d;
  logic                      load, fetch, hs, last;
  logic [BITS_PER_SYM-1:0]   bits;

  prbs_lfsr #(.WIDTH(LFSR_WIDTH), .STEP(BITS_PER_SYM)) u_prbs (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (load),
    .seed     (seed),
    .step_en  (fetch),
    .bits_out (bits)
  );

  assign lvl_i = LEVEL_W'(gray_to_level(3'(bits[BITS_PER_SYM-1:K]), K));
  assign lvl_q = LEVEL_W'(gray_to_level(3'(bits[K-1:0]), K));
  assign hs    = (state_q == RUN) && out_ready;
  assign last  = (ph_q == PH_LAST);

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    i_d      = i_q;
    q_d      = q_q;
    hold_d   = hold_q;
    strobe_d = strobe_q;
    load     = 1'b0;
    fetch    = 1'b0;
    case (state_q)
      // A seed load takes the cycle, so a simultaneous enable starts one cycle later
      IDLE: begin
        if (seed_load) load = 1'b1;
        else if (enable) begin
          fetch   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (!last) begin
            ph_d     = ph_q + 1'b1;
            strobe_d = 1'b0;
            i_d      = hold_q ? i_q : '0;
            q_d      = hold_q ? q_q : '0;
          end else if (enable) begin
            fetch = 1'b1;
          end else begin
            state_d  = IDLE;
            ph_d     = '0;
            strobe_d = 1'b0;
            i_d      = '0;
            q_d      = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fetch) begin
      ph_d     = '0;
      strobe_d = 1'b1;
      i_d      = lvl_i;
      q_d      = lvl_q;
      hold_d   = hold_mode;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      i_q      <= '0;
      q_q      <= '0;
      hold_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      i_q      <= i_d;
      q_q      <= q_d;
      hold_q   <= hold_d;
      strobe_q <= strobe_d;
    end
  end

  assign out_valid  = (state_q == RUN);
  assign i_out      = i_q;
  assign q_out      = q_q;
  assign sym_strobe = strobe_q;

`ifdef QAM_SRC_SYM_COUNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        cnt_q <= '0;
    else if (hs && last) cnt_q <= cnt_q + 32'd1;
  end
  assign sym_count = cnt_q;
`else
  assign sym_count = '0;
`endif

endmodule

// File: tb/tb_qam_symbol_source.sv
// Directed bench for qam_symbol_source: default 16-QAM instance tracked by a bit-serial
// PRBS15 model, plus a PRBS7/QPSK instance (seeding) and a 64-QAM UPSAMPLE=1 instance.
module tb_qam_symbol_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  // default instance
  logic              enable, hold_mode, seed_load, out_ready;
  logic [14:0]       seed;
  logic              out_valid, sym_strobe;
  logic signed [2:0] i_out, q_out;
  logic [31:0]       sym_count;
  // LFSR_WIDTH=7, BITS_PER_SYM=2, UPSAMPLE=2
  logic              enable7, seed_load7, out_ready7, hold7;
  logic [6:0]        seed7;
  logic              out_valid7, strobe7;
  logic signed [1:0] i7, q7;
  logic [31:0]       cnt7;
  // BITS_PER_SYM=6, UPSAMPLE=1
  logic              enable6, hold6, seed_load6, out_ready6;
  logic [14:0]       seed6;
  logic              out_valid6, strobe6;
  logic signed [3:0] i6, q6;
  logic [31:0]       cnt6;

  qam_symbol_source dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .hold_mode(hold_mode),
    .seed_load(seed_load), .seed(seed), .out_ready(out_ready), .out_valid(out_valid),
    .i_out(i_out), .q_out(q_out), .sym_strobe(sym_strobe), .sym_count(sym_count));

  qam_symbol_source #(.BITS_PER_SYM(2), .UPSAMPLE(2), .LFSR_WIDTH(7)) dut7 (
    .clk(clk), .reset_n(reset_n), .enable(enable7), .hold_mode(hold7),
    .seed_load(seed_load7), .seed(seed7), .out_ready(out_ready7), .out_valid(out_valid7),
    .i_out(i7), .q_out(q7), .sym_strobe(strobe7), .sym_count(cnt7));

  qam_symbol_source #(.BITS_PER_SYM(6), .UPSAMPLE(1), .LFSR_WIDTH(15)) dut6 (
    .clk(clk), .reset_n(reset_n), .enable(enable6), .hold_mode(hold6),
    .seed_load(seed_load6), .seed(seed6), .out_ready(out_ready6), .out_valid(out_valid6),
    .i_out(i6), .q_out(q6), .sym_strobe(strobe6), .sym_count(cnt6));

  int checks = 0;
  int errors = 0;

  // reference model of the default instance
  logic [14:0]       m;
  int                ph_e;   // -1: idle
  logic signed [2:0] si, sq;
  logic              hm_e;
  int                nsym;

  function automatic logic signed [2:0] lvl2(input logic [1:0] g);
    case (g)
      2'b00:   return -3'sd3;
      2'b01:   return -3'sd1;
      2'b11:   return 3'sd1;
      default: return 3'sd3;
    endcase
  endfunction

  function automatic logic signed [2:0] exp_i();
    return (ph_e == 0 || hm_e) ? si : 3'sd0;
  endfunction

  function automatic logic signed [2:0] exp_q();
    return (ph_e == 0 || hm_e) ? sq : 3'sd0;
  endfunction

  task automatic fetch();
    logic [3:0] b;
    for (int k = 3; k >= 0; k--) begin
      b[k] = m[14] ^ m[13];
      m    = {m[13:0], b[k]};
    end
    si   = lvl2(b[3:2]);
    sq   = lvl2(b[1:0]);
    hm_e = hold_mode;
    ph_e = 0;
  endtask

  // model one accepted sample
  task automatic step_model();
    if (ph_e == 3) begin
      nsym++;
      if (enable) fetch();
      else ph_e = -1;
    end else begin
      ph_e++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 0; hold_mode = 0; seed_load = 0; out_ready = 0; seed = '0;
    enable7 = 0; hold7 = 0; seed_load7 = 0; out_ready7 = 0; seed7 = '0;
    enable6 = 0; hold6 = 0; seed_load6 = 0; out_ready6 = 0; seed6 = '0;
    m = '1; ph_e = -1; si = 0; sq = 0; hm_e = 0; nsym = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || i_out !== 3'sd0 || q_out !== 3'sd0 || sym_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b i=%0d q=%0d s=%b, want 0 0 0 0",
               out_valid, i_out, q_out, sym_strobe);
    end
    checks++;
    if (sym_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_sym_count: got %0d want 0", sym_count);
    end
    checks++;
    if (out_valid7 !== 1'b0 || out_valid6 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_others: got %b %b want 0 0", out_valid7, out_valid6);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_zero_stuff();
    @(negedge clk);
    enable = 1; out_ready = 1; hold_mode = 0;
    fetch();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (i_out !== -3'sd3 || q_out !== -3'sd3 || sym_strobe !== 1'b1) begin
          errors++;
          $display("FAIL first_symbol: got i=%0d q=%0d s=%b want -3 -3 1", i_out, q_out, sym_strobe);
        end
      end
      checks++;
      if (out_valid !== 1'b1 || sym_strobe !== (ph_e == 0) || i_out !== exp_i() || q_out !== exp_q()) begin
        errors++;
        $display("FAIL zero_stuff n=%0d: got v=%b s=%b i=%0d q=%0d want v=1 s=%b i=%0d q=%0d",
                 n, out_valid, sym_strobe, i_out, q_out, ph_e == 0, exp_i(), exp_q());
      end
      if (n == 11) hold_mode = 1;
      step_model();
    end
  endtask

  task automatic test_hold();
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sym_strobe !== (n % 4 == 0) || i_out !== si || q_out !== sq) begin
        errors++;
        $display("FAIL hold n=%0d: got v=%b s=%b i=%0d q=%0d want v=1 s=%b i=%0d q=%0d",
                 n, out_valid, sym_strobe, i_out, q_out, n % 4 == 0, si, sq);
      end
      if (n == 7) hold_mode = 0;
      step_model();
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sym_strobe !== (ph_e == 0) || i_out !== exp_i() || q_out !== exp_q()) begin
        errors++;
        $display("FAIL backpressure n=%0d: got v=%b s=%b i=%0d q=%0d want v=1 s=%b i=%0d q=%0d",
                 n, out_valid, sym_strobe, i_out, q_out, ph_e == 0, exp_i(), exp_q());
      end
      out_ready = (n == 999) ? 1'b1 : 1'($urandom_range(0, 1));
      seed_load = (n == 999) ? 1'b0 : 1'($urandom_range(0, 1));  // must be ignored in RUN
      seed      = 15'($urandom);
      hold_mode = 1'($urandom_range(0, 1));
      if (out_ready) step_model();
    end
  endtask

  task automatic test_enable_drop();
    int extra;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ph_e == 1) break;
      step_model();
    end
    checks++;
    if (ph_e != 1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drop_align: got ph=%0d v=%b want ph=1 v=1", ph_e, out_valid);
    end
    enable = 0;
    step_model();
    extra = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra++;
      if (ph_e >= 0) step_model();
    end
    checks++;
    if (extra != 2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_tail: got %0d more samples v=%b want 2 v=0", extra, out_valid);
    end
    checks++;
`ifdef QAM_SRC_SYM_COUNT_EN
    if (sym_count !== 32'(nsym)) begin
      errors++;
      $display("FAIL sym_count: got %0d want %0d", sym_count, nsym);
    end
`else
    if (sym_count !== 32'd0) begin
      errors++;
      $display("FAIL sym_count: got %0d want 0", sym_count);
    end
`endif
  endtask

  task automatic test_seed();
    @(negedge clk);
    seed7 = 7'h00; seed_load7 = 1; enable7 = 1; out_ready7 = 1;
    @(negedge clk);
    seed_load7 = 0;
    checks++;
    if (out_valid7 !== 1'b0) begin
      errors++;
      $display("FAIL seed_delay: got v=%b want 0", out_valid7);
    end
    @(negedge clk);
    checks++;
    if (out_valid7 !== 1'b1 || strobe7 !== 1'b1 || i7 !== -2'sd1 || q7 !== -2'sd1) begin
      errors++;
      $display("FAIL seed_zero_first: got v=%b s=%b i=%0d q=%0d want 1 1 -1 -1", out_valid7, strobe7, i7, q7);
    end
    // fourth symbol from the all-ones state is bits 1,0
    repeat (6) @(negedge clk);
    checks++;
    if (strobe7 !== 1'b1 || i7 !== 2'sd1 || q7 !== -2'sd1) begin
      errors++;
      $display("FAIL seed_zero_sym3: got s=%b i=%0d q=%0d want 1 1 -1", strobe7, i7, q7);
    end
    enable7 = 0;
    @(negedge clk);
    checks++;
    if (out_valid7 !== 1'b1 || strobe7 !== 1'b0 || i7 !== 2'sd0 || q7 !== 2'sd0) begin
      errors++;
      $display("FAIL qpsk_stuff: got v=%b s=%b i=%0d q=%0d want 1 0 0 0", out_valid7, strobe7, i7, q7);
    end
    @(negedge clk);
    checks++;
    if (out_valid7 !== 1'b0) begin
      errors++;
      $display("FAIL qpsk_idle: got v=%b want 0", out_valid7);
    end
    seed7 = 7'h40; seed_load7 = 1;
    @(negedge clk);
    seed_load7 = 0; enable7 = 1;
    @(negedge clk);
    enable7 = 0;
    checks++;
    if (out_valid7 !== 1'b1 || i7 !== 2'sd1 || q7 !== -2'sd1) begin
      errors++;
      $display("FAIL seed_40: got v=%b i=%0d q=%0d want 1 1 -1", out_valid7, i7, q7);
    end
  endtask

  task automatic test_qam64();
    logic [63:0] seen;
    int          nseen, idx, bad;
    seen = '0; nseen = 0; bad = 0;
    @(negedge clk);
    enable6 = 1; out_ready6 = 1;
    for (int n = 0; n < 32768 && nseen < 64; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (i6 !== -4'sd7 || q6 !== -4'sd7) begin
          errors++;
          $display("FAIL qam64_first: got i=%0d q=%0d want -7 -7", i6, q6);
        end
      end
      if (out_valid6 !== 1'b1 || strobe6 !== 1'b1 || i6[0] !== 1'b1 || q6[0] !== 1'b1) begin
        bad++;
        if (bad < 5)
          $display("FAIL qam64_sample n=%0d: got v=%b s=%b i=%0d q=%0d want v=1 s=1 odd levels",
                   n, out_valid6, strobe6, i6, q6);
      end else begin
        idx = ((int'(i6) + 7) / 2) * 8 + (int'(q6) + 7) / 2;
        if (!seen[idx]) begin
          seen[idx] = 1'b1;
          nseen++;
        end
      end
    end
    enable6 = 0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL qam64_samples: got %0d bad samples want 0", bad);
    end
    checks++;
    if (nseen != 64) begin
      errors++;
      $display("FAIL qam64_coverage: got %0d distinct symbols want 64", nseen);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    enable = 1; out_ready = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart: got v=%b want 1", out_valid);
    end
    reset_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || i_out !== 3'sd0 || q_out !== 3'sd0 || sym_strobe !== 1'b0 || sym_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b i=%0d q=%0d s=%b cnt=%0d want all 0",
               out_valid, i_out, q_out, sym_strobe, sym_count);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_zero_stuff();
    test_hold();
    test_backpressure();
    test_enable_drop();
    test_seed();
    test_qam64();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
